// File: rtl/mips8_pkg.sv
// Shared constants and helpers for the 8-bit multicycle MIPS datapath.
// Holds next-PC select encodings, opcode values and instruction-register geometry.
package mips8_pkg;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned IR_BYTES = 4;
  localparam int unsigned IR_WIDTH = IR_BYTES * BYTE_W;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;

  typedef enum logic [1:0] {
    PCSRC_INC = 2'b00,
    PCSRC_BR  = 2'b01,
    PCSRC_JMP = 2'b10,
    PCSRC_RSV = 2'b11
  } pcsrc_e;

  typedef enum logic [OP_W-1:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    BEQ   = 6'h04,
    ADDI  = 6'h08,
    LB    = 6'h20,
    SB    = 6'h28
  } opcode_e;

  // True when more than one byte enable is active at once.
  function automatic logic multi_hot(input logic [IR_BYTES-1:0] v);
    return (v & (v - IR_BYTES'(1))) != '0;
  endfunction

endpackage

// File: rtl/mips8_fetch_unit_if.sv
// Controller/memory-facing bus of the fetch unit.
// master = controller and memory side, slave = fetch unit.
interface mips8_fetch_unit_if #(
  parameter int unsigned WIDTH = mips8_pkg::WIDTH
);
  import mips8_pkg::*;

  logic                  memread;
  logic [IR_BYTES-1:0]   irwrite;
  logic                  pcen;
  logic [1:0]            pcsrc;
  logic                  iord;
  logic [WIDTH-1:0]      alu_result;
  logic [WIDTH-1:0]      alu_out;
  logic [WIDTH-1:0]      memdata;
  logic                  mem_ready;

  logic [WIDTH-1:0]      adr;
  logic [WIDTH-1:0]      pc;
  logic [IR_WIDTH-1:0]   instr;
  logic [OP_W-1:0]       op;
  logic [FUNCT_W-1:0]    funct;
  logic                  ir_valid;
  logic                  stall;
  logic                  err;

  modport master (
    output memread, irwrite, pcen, pcsrc, iord, alu_result, alu_out, memdata, mem_ready,
    input  adr, pc, instr, op, funct, ir_valid, stall, err
  );

  modport slave (
    input  memread, irwrite, pcen, pcsrc, iord, alu_result, alu_out, memdata, mem_ready,
    output adr, pc, instr, op, funct, ir_valid, stall, err
  );

endinterface

// File: rtl/mips8_ir_bytereg.sv
// Four-byte instruction register with per-byte enables, a byte-valid mask
// and detection of multiple simultaneous enables.
module mips8_ir_bytereg
  import mips8_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [IR_BYTES-1:0] be,
  input  logic [BYTE_W-1:0]   din,
  output logic [IR_WIDTH-1:0] q,
  output logic [IR_BYTES-1:0] mask,
  output logic                multi_c
);

  logic [IR_WIDTH-1:0] q_q, q_d;
  logic [IR_BYTES-1:0] mask_q, mask_d;

  // Writing byte 0 starts a fresh instruction; other bytes accumulate.
  always_comb begin
    q_d    = q_q;
    mask_d = mask_q;
    if (we) begin
      for (int k = 0; k < int'(IR_BYTES); k++) begin
        if (be[k]) q_d[k*BYTE_W +: BYTE_W] = din;
      end
      mask_d = be[0] ? IR_BYTES'(1) : (mask_q | be);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= '0;
      mask_q <= '0;
    end else begin
      q_q    <= q_d;
      mask_q <= mask_d;
    end
  end

  assign q       = q_q;
  assign mask    = mask_q;
  assign multi_c = multi_hot(be);

endmodule

// File: rtl/mips8_fetch_unit.sv
// Fetch-side register stage: PC, address mux, byte-assembled IR and
// memory wait handshake feeding the multicycle controller.
module mips8_fetch_unit #(
  parameter int unsigned     WIDTH    = mips8_pkg::WIDTH,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic               clk,
  input  logic               reset,
  mips8_fetch_unit_if.slave  bus
);
  import mips8_pkg::*;

  logic [WIDTH-1:0]    pc_q, pc_d;
  logic                err_q, err_d;
  logic                stall_c;
  logic                pc_err_c;
  logic                multi_c;
  logic [IR_WIDTH-1:0] instr;
  logic [IR_BYTES-1:0] mask;
  pcsrc_e              pcsrc;

  assign stall_c = bus.memread & ~bus.mem_ready;
  assign pcsrc   = pcsrc_e'(bus.pcsrc);

  mips8_ir_bytereg u_ir (
    .clk     (clk),
    .reset   (reset),
    .we      (~stall_c),
    .be      (bus.irwrite),
    .din     (BYTE_W'(bus.memdata)),
    .q       (instr),
    .mask    (mask),
    .multi_c (multi_c)
  );

  // Next-PC select; the jump target comes from the pre-edge IR.
  always_comb begin
    pc_d     = pc_q;
    pc_err_c = 1'b0;
    if (bus.pcen && !stall_c) begin
      unique case (pcsrc)
        PCSRC_INC: pc_d = bus.alu_result;
        PCSRC_BR:  pc_d = bus.alu_out;
        PCSRC_JMP: pc_d = WIDTH'({instr[FUNCT_W-1:0], 2'b00});
        default:   pc_err_c = 1'b1;
      endcase
    end
  end

  // Sticky error: reserved PC select or more than one IR byte enable.
  always_comb begin
    err_d = err_q | pc_err_c | (multi_c & ~stall_c);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= PC_RESET;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign bus.adr      = bus.iord ? bus.alu_out : pc_q;
  assign bus.pc       = pc_q;
  assign bus.instr    = instr;
  assign bus.op       = instr[IR_WIDTH-1 -: OP_W];
  assign bus.funct    = instr[FUNCT_W-1:0];
  assign bus.ir_valid = (mask == '1);
  assign bus.stall    = stall_c;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_mips8_fetch_unit.sv
// Bench for mips8_fetch_unit: directed scenarios plus randomized traffic
// compared each cycle against a byte-array reference model.
module tb_mips8_fetch_unit;

  logic clk;
  logic reset;

  mips8_fetch_unit_if #(.WIDTH(8)) bus ();

  mips8_fetch_unit #(.WIDTH(8), .PC_RESET(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Reference model state
  logic [7:0] m_pc;
  logic [7:0] m_ib [4];
  bit         m_v  [4];
  bit         m_err;
  bit         known = 1'b0;

  function automatic logic [31:0] model_instr();
    return {m_ib[3], m_ib[2], m_ib[1], m_ib[0]};
  endfunction

  function automatic logic [7:0] model_adr();
    return bus.iord ? bus.alu_out : m_pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic [31:0] ins;
    ins = model_instr();
    chk("adr",      32'(bus.adr),      32'(model_adr()));
    chk("pc",       32'(bus.pc),       32'(m_pc));
    chk("instr",    bus.instr,         ins);
    chk("op",       32'(bus.op),       ins / 32'h0400_0000);
    chk("funct",    32'(bus.funct),    ins % 32'd64);
    chk("ir_valid", 32'(bus.ir_valid), 32'(m_v[0] && m_v[1] && m_v[2] && m_v[3]));
    chk("stall",    32'(bus.stall),    32'(bus.memread && !bus.mem_ready));
    chk("err",      32'(bus.err),      32'(m_err));
  endtask

  task automatic model_step();
    logic [31:0] old;
    int n;
    if (reset) begin
      m_pc  = 8'h00;
      m_err = 1'b0;
      for (int k = 0; k < 4; k++) begin
        m_ib[k] = 8'h00;
        m_v[k]  = 1'b0;
      end
      known = 1'b1;
    end else if (!(bus.memread && !bus.mem_ready)) begin
      old = model_instr();
      n = 0;
      for (int k = 0; k < 4; k++) begin
        if (bus.irwrite[k]) begin
          m_ib[k] = bus.memdata;
          n++;
        end
      end
      if (bus.irwrite[0]) begin
        for (int k = 0; k < 4; k++) m_v[k] = (k == 0);
      end else begin
        for (int k = 0; k < 4; k++) if (bus.irwrite[k]) m_v[k] = 1'b1;
      end
      if (n > 1) m_err = 1'b1;
      if (bus.pcen) begin
        case (bus.pcsrc)
          2'd0: m_pc = bus.alu_result;
          2'd1: m_pc = bus.alu_out;
          2'd2: m_pc = 8'((old % 32'd64) * 32'd4);
          default: m_err = 1'b1;
        endcase
      end
    end
  endtask

  task automatic cycle();
    #1;
    if (known) compare();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    reset          = 1'b0;
    bus.memread    = 1'b0;
    bus.irwrite    = 4'b0000;
    bus.pcen       = 1'b0;
    bus.pcsrc      = 2'b00;
    bus.iord       = 1'b0;
    bus.alu_result = 8'h00;
    bus.alu_out    = 8'h00;
    bus.memdata    = 8'h00;
    bus.mem_ready  = 1'b1;
  endtask

  task automatic drive_random();
    int r;
    reset          = ($urandom_range(0, 99) < 2);
    bus.memread    = 1'($urandom_range(0, 1));
    bus.mem_ready  = ($urandom_range(0, 3) != 0);
    r = $urandom_range(0, 19);
    if (r < 14)      bus.irwrite = 4'(1 << $urandom_range(0, 3));
    else if (r < 18) bus.irwrite = 4'b0000;
    else             bus.irwrite = 4'($urandom);
    bus.pcen       = ($urandom_range(0, 2) == 0);
    bus.pcsrc      = ($urandom_range(0, 29) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    bus.iord       = 1'($urandom_range(0, 1));
    bus.alu_result = 8'($urandom);
    bus.alu_out    = 8'($urandom);
    bus.memdata    = 8'($urandom);
  endtask

  logic [7:0] fetch_bytes [4];

  initial begin
    fetch_bytes[0] = 8'h8C;
    fetch_bytes[1] = 8'hA3;
    fetch_bytes[2] = 8'h00;
    fetch_bytes[3] = 8'h44;

    // Reset held two cycles
    idle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    #1;
    chk("rst_pc",       32'(bus.pc),       32'h00);
    chk("rst_instr",    bus.instr,         32'h0);
    chk("rst_ir_valid", 32'(bus.ir_valid), 32'h0);
    chk("rst_err",      32'(bus.err),      32'h0);
    chk("rst_adr",      32'(bus.adr),      32'h00);

    // Four-byte fetch
    for (int i = 0; i < 4; i++) begin
      bus.memread = 1'b1;
      bus.irwrite = 4'(1 << i);
      bus.memdata = fetch_bytes[i];
      cycle();
    end
    idle();
    #1;
    chk("fetch_instr", bus.instr,         32'h4400A38C);
    chk("fetch_op",    32'(bus.op),       32'h11);
    chk("fetch_funct", 32'(bus.funct),    32'h0C);
    chk("fetch_valid", 32'(bus.ir_valid), 32'h1);

    // Memory wait on byte 1
    bus.memread   = 1'b1;
    bus.irwrite   = 4'b0010;
    bus.mem_ready = 1'b0;
    bus.memdata   = 8'hEE;
    repeat (3) begin
      #1;
      chk("wait_stall", 32'(bus.stall),      32'h1);
      chk("wait_byte1", 32'(bus.instr[15:8]), 32'hA3);
      cycle();
    end
    bus.mem_ready = 1'b1;
    bus.memdata   = 8'h5A;
    #1;
    chk("ready_stall", 32'(bus.stall), 32'h0);
    cycle();
    idle();
    #1;
    chk("ready_byte1", 32'(bus.instr[15:8]), 32'h5A);

    // PC updates: increment, wrap, jump, reserved
    bus.pcen = 1'b1;
    bus.pcsrc = 2'b00;
    bus.alu_result = 8'hFF;
    cycle();
    #1;
    chk("pc_ff", 32'(bus.pc), 32'hFF);
    bus.alu_result = 8'h00;
    cycle();
    #1;
    chk("pc_wrap", 32'(bus.pc), 32'h00);
    bus.pcsrc = 2'b10;
    cycle();
    #1;
    chk("pc_jump", 32'(bus.pc), 32'h30);
    bus.pcsrc = 2'b11;
    cycle();
    #1;
    chk("pc_rsv_hold", 32'(bus.pc),  32'h30);
    chk("pc_rsv_err",  32'(bus.err), 32'h1);

    // Simultaneous PC write and byte-0 fetch from the pre-edge PC
    idle();
    bus.pcen = 1'b1;
    bus.alu_result = 8'h10;
    cycle();
    idle();
    bus.memread    = 1'b1;
    bus.irwrite    = 4'b0001;
    bus.memdata    = 8'hC3;
    bus.pcen       = 1'b1;
    bus.pcsrc      = 2'b00;
    bus.alu_result = 8'h11;
    #1;
    chk("sim_adr", 32'(bus.adr), 32'h10);
    cycle();
    idle();
    #1;
    chk("sim_pc",    32'(bus.pc),         32'h11);
    chk("sim_byte0", 32'(bus.instr[7:0]), 32'hC3);
    chk("sim_valid", 32'(bus.ir_valid),   32'h0);

    // Reset mid-fetch, then multi-hot byte enable
    reset = 1'b1;
    cycle();
    idle();
    bus.memread = 1'b1;
    bus.irwrite = 4'b0001;
    bus.memdata = 8'h11;
    cycle();
    bus.irwrite = 4'b0010;
    bus.memdata = 8'h22;
    cycle();
    idle();
    reset = 1'b1;
    cycle();
    idle();
    #1;
    chk("midrst_valid", 32'(bus.ir_valid), 32'h0);
    chk("midrst_instr", bus.instr,         32'h0);
    chk("midrst_err",   32'(bus.err),      32'h0);
    bus.memread = 1'b1;
    bus.irwrite = 4'b0011;
    bus.memdata = 8'h77;
    cycle();
    idle();
    #1;
    chk("multi_err",   32'(bus.err), 32'h1);
    chk("multi_instr", bus.instr,    32'h00007777);

    // Randomized traffic
    reset = 1'b1;
    cycle();
    repeat (3000) begin
      drive_random();
      cycle();
    end
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
